// File: rtl/mem_bank_writer.sv
// mem_bank_writer: 64x20 register bank fed by a 2-entry write queue, with a full-bank clear sweep.
// Optional per-bit write mask is enabled by defining MEM_BANK_WRITE_MASK_EN.
module mem_bank_writer (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [5:0]    wr_addr,
    input  logic [19:0]   wr_data,
`ifdef MEM_BANK_WRITE_MASK_EN
    input  logic [19:0]   wr_mask,
`endif
    input  logic          clr_req,
    output logic          wr_done,
    output logic          clr_done,
    output logic          busy,
    output logic [1279:0] mem
);
    localparam int unsigned Words = 64;
    localparam int unsigned Width = 20;
    localparam int unsigned Depth = 2;

    typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

    state_e            state_q, state_d;
    logic              pending_q, pending_d;
    logic [5:0]        q_addr_q [Depth];
    logic [Width-1:0]  q_data_q [Depth];
    logic [Width-1:0]  q_mask_q [Depth];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        count_q, count_d;
    logic [5:0]        sweep_q;
    logic              wr_done_q, clr_done_q;
    logic [Width-1:0]  mem_q [Words];
    logic              accept, commit, sweep_last;
    logic [Width-1:0]  in_mask, head_mask, head_data;
    logic [5:0]        head_addr;

`ifdef MEM_BANK_WRITE_MASK_EN
    assign in_mask = wr_mask;
`else
    assign in_mask = '1;
`endif

    assign accept     = wr_valid & wr_ready;
    assign commit     = (count_q != 2'd0) && (state_q != StClear);
    assign sweep_last = (state_q == StClear) && (sweep_q == 6'd63);
    assign count_d    = count_q + {1'b0, accept} - {1'b0, commit};
    assign head_addr  = q_addr_q[rd_ptr_q];
    assign head_data  = q_data_q[rd_ptr_q];
    assign head_mask  = q_mask_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            StIdle: begin
                // A write accepted alongside a clear request goes first; the clear follows it.
                if (accept) begin
                    state_d   = StDrain;
                    pending_d = clr_req;
                end else if (clr_req) begin
                    state_d = StClear;
                end
            end
            StDrain: begin
                if (clr_req) pending_d = 1'b1;
                if (count_d == 2'd0) begin
                    state_d   = pending_d ? StClear : StIdle;
                    pending_d = 1'b0;
                end
            end
            StClear: begin
                if (sweep_q == 6'd63) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ready = ~rst && (count_q < 2'd2) && (state_q != StClear) && ~pending_q;
        busy     = ~rst && ((count_q != 2'd0) || pending_q || (state_q == StClear));
        wr_done  = wr_done_q;
        clr_done = clr_done_q;
    end

    // Queue payload needs no reset: entries are only read when count_q says they are valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_addr_q[wr_ptr_q] <= wr_addr;
            q_data_q[wr_ptr_q] <= wr_data;
            q_mask_q[wr_ptr_q] <= in_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            sweep_q    <= 6'd0;
            wr_done_q  <= 1'b0;
            clr_done_q <= 1'b0;
            for (int i = 0; i < Words; i++) mem_q[i] <= '0;
        end else begin
            count_q    <= count_d;
            wr_done_q  <= commit;
            clr_done_q <= sweep_last;
            if (accept) wr_ptr_q <= ~wr_ptr_q;
            if (commit) begin
                mem_q[head_addr] <= (mem_q[head_addr] & ~head_mask) | (head_data & head_mask);
                rd_ptr_q         <= ~rd_ptr_q;
            end
            if (state_q == StClear) begin
                mem_q[sweep_q] <= '0;
                sweep_q        <= sweep_q + 6'd1;
            end else begin
                sweep_q <= 6'd0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < Words; i++) mem[i*Width +: Width] = mem_q[i];
    end

endmodule

// File: tb/tb_mem_bank_writer.sv
// Self-checking bench for mem_bank_writer: vector table, directed clear/reset sequences,
// and randomized writes against a queue-based reference model.
module tb_mem_bank_writer;
    logic          clk = 1'b0;
    logic          rst, wr_valid, clr_req;
    logic [5:0]    wr_addr;
    logic [19:0]   wr_data, tb_mask;
    logic          wr_ready, wr_done, clr_done, busy;
    logic [1279:0] mem;
    logic [19:0]   ref_mem [64];
    int            checks = 0;
    int            failures = 0;

`ifdef MEM_BANK_WRITE_MASK_EN
    localparam bit MaskOn = 1'b1;
`else
    localparam bit MaskOn = 1'b0;
`endif

    typedef struct {
        logic [5:0]  addr;
        logic [19:0] data;
        logic [19:0] exp;
    } vec_t;

    typedef struct {
        logic [5:0]  a;
        logic [19:0] d;
        logic [19:0] m;
    } ent_t;

    mem_bank_writer dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
`ifdef MEM_BANK_WRITE_MASK_EN
        .wr_mask  (tb_mask),
`endif
        .clr_req  (clr_req),
        .wr_done  (wr_done),
        .clr_done (clr_done),
        .busy     (busy),
        .mem      (mem)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] word(input int i);
        return mem[20*i +: 20];
    endfunction

    function automatic logic [19:0] eff_mask(input logic [19:0] m);
        return MaskOn ? m : 20'hFFFFF;
    endfunction

    function automatic int mism();
        int n = 0;
        for (int i = 0; i < 64; i++) if (word(i) !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        tb_mask  = 20'hFFFFF;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    endtask

    // Returns just after the handshake edge with wr_valid dropped.
    task automatic write(input logic [5:0] a, input logic [19:0] d);
        int n = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        while (!wr_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("write_ready_timeout", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0;
        ref_mem[a] = (ref_mem[a] & ~eff_mask(tb_mask)) | (d & eff_mask(tb_mask));
    endtask

    vec_t vecs[6];

    initial begin
        int   n, bad, pulses;
        ent_t q[$];
        ent_t e;
        logic exp_ready, exp_done, acc;

        vecs[0] = '{addr: 6'd0,  data: 20'h00001, exp: 20'h00001};
        vecs[1] = '{addr: 6'd63, data: 20'hFFFFF, exp: 20'hFFFFF};
        vecs[2] = '{addr: 6'd31, data: 20'hAAAAA, exp: 20'hAAAAA};
        vecs[3] = '{addr: 6'd32, data: 20'h55555, exp: 20'h55555};
        vecs[4] = '{addr: 6'd1,  data: 20'h80000, exp: 20'h80000};
        vecs[5] = '{addr: 6'd0,  data: 20'h12345, exp: 20'h12345};

        // Reset state
        rst = 1'b1;
        idle_inputs();
        tick();
        chk("ready_in_reset", {31'd0, wr_ready}, 32'd0);
        chk("busy_in_reset", {31'd0, busy}, 32'd0);
        chk("wr_done_in_reset", {31'd0, wr_done}, 32'd0);
        chk("clr_done_in_reset", {31'd0, clr_done}, 32'd0);
        do_reset();
        chk("ready_after_reset", {31'd0, wr_ready}, 32'd1);
        chk("mem_zero_after_reset", mism(), 0);

        // Single write latency
        wr_valid = 1'b1;
        wr_addr  = 6'd5;
        wr_data  = 20'hABCDE;
        tick();
        wr_valid = 1'b0;
        ref_mem[5] = 20'hABCDE;
        chk("w5_not_yet", word(5), 20'h0);
        chk("w5_busy", {31'd0, busy}, 32'd1);
        chk("w5_done_early", {31'd0, wr_done}, 32'd0);
        tick();
        chk("w5_data", word(5), 20'hABCDE);
        chk("w5_done", {31'd0, wr_done}, 32'd1);
        tick();
        chk("w5_done_once", {31'd0, wr_done}, 32'd0);
        chk("w5_idle", {31'd0, busy}, 32'd0);
        chk("w5_mem", mism(), 0);

        // Vector table
        foreach (vecs[i]) begin
            write(vecs[i].addr, vecs[i].data);
            tick();
            chk("vec_word", word(vecs[i].addr), vecs[i].exp);
            chk("vec_done", {31'd0, wr_done}, 32'd1);
        end
        tick();
        chk("vec_mem", mism(), 0);

        // Streamed writes to 0,1,2
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_addr = 6'(i);
            wr_data = 20'(i + 1);
            chk("stream_ready", {31'd0, wr_ready}, 32'd1);
            tick();
            ref_mem[i] = 20'(i + 1);
            if (i == 1) chk("stream_order_w0", word(0), 20'd1);
            if (i == 2) chk("stream_order_w1", word(1), 20'd2);
        end
        wr_valid = 1'b0;
        tick();
        chk("stream_w2", word(2), 20'd3);
        chk("stream_mem", mism(), 0);

        // Same address back to back
        write(6'd63, 20'h11111);
        write(6'd63, 20'h22222);
        chk("b2b_first", word(63), 20'h11111);
        tick();
        chk("b2b_last_wins", word(63), 20'h22222);

`ifdef MEM_BANK_WRITE_MASK_EN
        tb_mask = 20'hFFFFF;
        write(6'd7, 20'hFFFFF);
        tick();
        tb_mask = 20'h0000F;
        write(6'd7, 20'h00000);
        tick();
        chk("mask_w7", word(7), 20'hFFFF0);
        tb_mask = 20'hFFFFF;
        chk("mask_mem", mism(), 0);
`endif

        // Clear requested while draining
        wr_valid = 1'b1;
        wr_addr  = 6'd10;
        wr_data  = 20'h1234A;
        tick();
        wr_addr  = 6'd11;
        wr_data  = 20'h5678B;
        clr_req  = 1'b1;
        chk("clr_ready_before", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        chk("clr_ready_pending", {31'd0, wr_ready}, 32'd0);
        chk("clr_w10", word(10), 20'h1234A);
        tick();
        chk("clr_w11", word(11), 20'h5678B);
        chk("clr_w11_done", {31'd0, wr_done}, 32'd1);
        n = 0;
        bad = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (i == 10) begin
                chk("sweep_w9_zero", word(9), 20'h0);
                chk("sweep_w10_kept", word(10), 20'h1234A);
            end
            if (clr_done) begin
                n = i;
                break;
            end
            if (wr_ready) bad++;
        end
        chk("sweep_len", n, 64);
        chk("sweep_ready_low", bad, 0);
        tick();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        chk("sweep_done_once", {31'd0, clr_done}, 32'd0);
        chk("sweep_ready_after", {31'd0, wr_ready}, 32'd1);
        chk("sweep_busy_after", {31'd0, busy}, 32'd0);
        chk("sweep_mem_zero", mism(), 0);

        // Reset in the middle of a sweep
        write(6'd29, 20'h0A0A0);
        write(6'd30, 20'h0B0B0);
        write(6'd63, 20'h0C0C0);
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("abort_w29_zero", word(29), 20'h0);
        chk("abort_w30_kept", word(30), 20'h0B0B0);
        rst = 1'b1;
        #1;
        chk("abort_ready_in_rst", {31'd0, wr_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        chk("abort_mem_zero", mism(), 0);
        chk("abort_ready", {31'd0, wr_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            if (clr_done || wr_done) pulses++;
            tick();
        end
        chk("abort_no_pulses", pulses, 0);
        chk("abort_mem_hold", mism(), 0);

        // Randomized writes against a queue model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_addr  = 6'($urandom_range(0, 63));
            wr_data  = 20'($urandom);
            tb_mask  = 20'($urandom);
            exp_ready = (q.size() < 2);
            chk("rand_ready", {31'd0, wr_ready}, {31'd0, exp_ready});
            acc = wr_valid && exp_ready;
            tick();
            exp_done = (q.size() > 0);
            if (exp_done) begin
                e = q.pop_front();
                ref_mem[e.a] = (ref_mem[e.a] & ~e.m) | (e.d & e.m);
            end
            if (acc) q.push_back('{a: wr_addr, d: wr_data, m: eff_mask(tb_mask)});
            chk("rand_done", {31'd0, wr_done}, {31'd0, exp_done});
            chk("rand_mem", mism(), 0);
        end
        idle_inputs();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
